// File: rtl/clint_multi.sv
// Multi-hart core-local interruptor: mtime timebase, per-hart mtimecmp/msip,
// registered mtip, single-cycle bus response on the peripheral memory bus.
module clint_multi #(
  parameter int          harts      = 1,
  parameter int unsigned clk_freq   = 1000000000,
  parameter int unsigned rtc_freq   = 100000000,
  parameter logic [31:0] base_addr  = 32'h0200_0000,
  parameter int          time_width = 64
) (
  input  logic                  reset,
  input  logic                  clock,
  input  logic                  mem_valid,
  input  logic                  mem_instr,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_rdata,
  output logic                  mem_ready,
  output logic [time_width-1:0] mtime_out,
  output logic [harts-1:0]      mtip,
  output logic [harts-1:0]      msip
);

  localparam int unsigned DIV = clk_freq / rtc_freq;
  localparam int          CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  tick;
  logic [time_width-1:0] mtime_q, mtime_d;
  logic [time_width-1:0] cmp_q [harts];
  logic [time_width-1:0] cmp_d [harts];
  logic [harts-1:0]      msip_q, msip_d;
  logic [harts-1:0]      mtip_q, mtip_d;
  logic                  ready_q;
  logic [31:0]           rdata_q, rdata_d;

  logic [31:0] off;
  logic        in_win, acc, wr;
  logic        sel_msip, sel_cmp, sel_mtime;
  logic [11:0] idx_msip;
  logic [10:0] idx_cmp;
  logic        hi_word;
  logic [63:0] tmp;
  logic        unused_addr_bits;

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wd,
                                        input logic [3:0]  ws);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Offset arithmetic wraps, so addresses below base_addr fall outside the window.
  assign off              = mem_addr - base_addr;
  assign in_win           = (off[31:16] == 16'h0000);
  assign acc              = mem_valid & ~mem_instr;
  assign wr               = acc & (|mem_wstrb);
  assign sel_msip         = in_win & (off[15:14] == 2'b00);
  assign sel_cmp          = in_win & (off[15:14] == 2'b01);
  assign sel_mtime        = in_win & (off[15:3] == 13'h17FF);
  assign idx_msip         = off[13:2];
  assign idx_cmp          = off[13:3];
  assign hi_word          = off[2];
  assign unused_addr_bits = ^off[1:0];

  assign tick  = (cnt_q == CW'(DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_comb begin
    mtime_d = mtime_q + time_width'(tick);
    msip_d  = msip_q;
    cmp_d   = cmp_q;
    rdata_d = '0;
    tmp     = '0;

    // Write lanes land on top of the incremented value, so a coincident tick
    // still reaches the bytes that were not written.
    if (acc && sel_mtime) begin
      tmp     = 64'(mtime_q);
      rdata_d = hi_word ? tmp[63:32] : tmp[31:0];
      if (wr) begin
        tmp = 64'(mtime_d);
        if (hi_word) tmp[63:32] = merge(tmp[63:32], mem_wdata, mem_wstrb);
        else         tmp[31:0]  = merge(tmp[31:0],  mem_wdata, mem_wstrb);
        mtime_d = tmp[time_width-1:0];
      end
    end

    for (int h = 0; h < harts; h++) begin
      if (acc && sel_msip && (32'(idx_msip) == h)) begin
        rdata_d = {31'b0, msip_q[h]};
        if (wr && mem_wstrb[0]) msip_d[h] = mem_wdata[0];
      end
      if (acc && sel_cmp && (32'(idx_cmp) == h)) begin
        tmp     = 64'(cmp_q[h]);
        rdata_d = hi_word ? tmp[63:32] : tmp[31:0];
        if (wr) begin
          if (hi_word) tmp[63:32] = merge(tmp[63:32], mem_wdata, mem_wstrb);
          else         tmp[31:0]  = merge(tmp[31:0],  mem_wdata, mem_wstrb);
          cmp_d[h] = tmp[time_width-1:0];
        end
      end
    end

    for (int h = 0; h < harts; h++)
      mtip_d[h] = (mtime_d >= cmp_d[h]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      mtime_q <= '0;
      msip_q  <= '0;
      mtip_q  <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      for (int h = 0; h < harts; h++) cmp_q[h] <= '1;
    end else begin
      cnt_q   <= cnt_d;
      mtime_q <= mtime_d;
      msip_q  <= msip_d;
      mtip_q  <= mtip_d;
      ready_q <= mem_valid;
      rdata_q <= rdata_d;
      for (int h = 0; h < harts; h++) cmp_q[h] <= cmp_d[h];
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = ready_q ? rdata_q : '0;
  assign mtime_out = mtime_q;
  assign mtip      = mtip_q;
  assign msip      = msip_q;

endmodule

// File: tb/tb_clint_multi.sv
// Bench for clint_multi: directed scenarios plus random bus traffic, every cycle
// compared against an arithmetic model of the register map and timebase.
module tb_clint_multi;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, instr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [63:0] mtime;
  logic [1:0]  mtip, msip;

  logic [31:0] unused_rdata1;
  logic        unused_ready1;
  logic [39:0] mtime1;
  logic [0:0]  unused_mtip1, unused_msip1;

  clint_multi #(.harts(2)) dut (
    .reset(rst_n), .clock(clk), .mem_valid(valid), .mem_instr(instr),
    .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
    .mem_rdata(rdata), .mem_ready(ready), .mtime_out(mtime),
    .mtip(mtip), .msip(msip)
  );

  clint_multi #(.harts(1), .rtc_freq(1000000000), .time_width(40)) dut1 (
    .reset(rst_n), .clock(clk), .mem_valid(1'b0), .mem_instr(1'b0),
    .mem_addr(32'h0), .mem_wdata(32'h0), .mem_wstrb(4'h0),
    .mem_rdata(unused_rdata1), .mem_ready(unused_ready1), .mtime_out(mtime1),
    .mtip(unused_mtip1), .msip(unused_msip1)
  );

  always #5 clk = ~clk;

  // Reference state: edges since reset release, mtime, mtimecmp, msip.
  longint unsigned n;
  logic [63:0] m_time;
  logic [63:0] m_cmp [2];
  logic [1:0]  m_msip;
  int neval = 0, nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    neval++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] o = (a - BASE) & ~32'h3;
    int h;
    if (o >= 32'h1_0000) return 32'h0;
    if (o < 32'h4000) begin
      h = int'(o / 4);
      return (h < 2) ? {31'b0, m_msip[h]} : 32'h0;
    end
    if (o < 32'h4000 + 16) begin
      h = int'((o - 32'h4000) / 8);
      return o[2] ? m_cmp[h][63:32] : m_cmp[h][31:0];
    end
    if (o == 32'hBFF8) return m_time[31:0];
    if (o == 32'hBFFC) return m_time[63:32];
    return 32'h0;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] o = (a - BASE) & ~32'h3;
    int h;
    if (o >= 32'h1_0000) return;
    if (o < 32'h4000) begin
      h = int'(o / 4);
      if (h < 2 && ws[0]) m_msip[h] = wd[0];
    end else if (o < 32'h4000 + 16) begin
      h = int'((o - 32'h4000) / 8);
      if (o[2]) m_cmp[h][63:32] = lanes(m_cmp[h][63:32], wd, ws);
      else      m_cmp[h][31:0]  = lanes(m_cmp[h][31:0],  wd, ws);
    end else if (o == 32'hBFF8) m_time[31:0]  = lanes(m_time[31:0],  wd, ws);
    else if (o == 32'hBFFC)     m_time[63:32] = lanes(m_time[63:32], wd, ws);
  endtask

  task automatic m_reset();
    n = 0; m_time = '0; m_msip = '0;
    m_cmp[0] = '1; m_cmp[1] = '1;
  endtask

  // One clock: drive at the current negedge, model the posedge, check 1 time unit later.
  task automatic step(input logic v, input logic fi, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] rd, exp_rd;
    valid = v; instr = fi; addr = a; wdata = wd; wstrb = ws;
    @(posedge clk);
    rd = m_read(a);
    n++;
    if (n % 10 == 0) m_time++;
    if (v && !fi && ws != 4'h0) m_write(a, wd, ws);
    exp_rd = (v && !fi) ? rd : 32'h0;
    #1;
    chk("ready", ready, v);
    chk("rdata", rdata, exp_rd);
    chk("mtime", mtime, m_time);
    chk("msip", msip, m_msip);
    chk("mtip", mtip, {m_time >= m_cmp[1], m_time >= m_cmp[0]});
    chk("mtime_div1", mtime1, n[39:0]);
    @(negedge clk);
  endtask

  task automatic idle();                                     step(0, 0, 32'h0, 32'h0, 4'h0); endtask
  task automatic wr(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s); step(1, 0, BASE + o, d, s); endtask
  task automatic rd(input logic [31:0] o);                   step(1, 0, BASE + o, 32'h0, 4'h0); endtask

  localparam int NOFF = 14;
  logic [31:0] offs [NOFF] = '{32'h0, 32'h4, 32'h8, 32'h4000, 32'h4004, 32'h4008, 32'h400C,
                               32'h4010, 32'hBFF8, 32'hBFFC, 32'h8000, 32'h1_0000,
                               32'hFFFF_FFFC, 32'h3FFC};

  initial begin
    m_reset();
    #2;
    chk("rst_mtime", mtime, 64'h0);
    chk("rst_mtip", mtip, 2'b00);
    chk("rst_msip", msip, 2'b00);
    chk("rst_ready", ready, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    repeat (100) idle();
    chk("mtime_after_100", mtime, 64'd10);
    rd(32'hBFF8);
    chk("read_mtime_lo", rdata, 32'd10);
    step(1, 1, BASE + 32'hBFF8, 32'h0, 4'h0);
    chk("fetch_reads_zero", rdata, 32'h0);
    rd(32'hBFFA);

    wr(32'h400C, 32'h0, 4'hF);
    wr(32'h4008, 32'h20, 4'hF);
    for (int i = 0; i < 400 && m_time < 64'h20; i++) idle();
    chk("mtime_reached_20", mtime, 64'h20);
    chk("mtip_at_20", mtip, 2'b10);
    idle();
    wr(32'h400C, 32'hFFFF_FFFF, 4'hF);
    chk("mtip_cleared", mtip, 2'b00);

    wr(32'h0004, 32'h1, 4'hF);
    chk("msip_set", msip, 2'b10);
    wr(32'h0004, 32'hFFFF_FFFE, 4'hF);
    chk("msip_clr", msip, 2'b00);
    rd(32'h0004);
    chk("msip_read", rdata, 32'h0);

    for (int i = 0; i < 10 && (n + 1) % 10 != 0; i++) idle();
    wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    chk("mtime_write_on_tick", mtime, 64'h0000_0000_FFFF_FFFF);
    repeat (10) idle();
    chk("mtime_carry", mtime, 64'h1_0000_0000);

    rd(32'h8000);
    chk("hole_read", rdata, 32'h0);
    rd(32'h4010);
    chk("cmp_h2_read", rdata, 32'h0);
    wr(32'h4010, 32'h1234_5678, 4'hF);
    wr(32'h8000, 32'hFFFF_FFFF, 4'hF);
    wr(32'h0008, 32'h1, 4'hF);
    wr(32'h4000, 32'h0000_AB00, 4'b0010);
    rd(32'h4000);
    chk("byte_lane_write", rdata, 32'hFFFF_ABFF);
    rd(32'h4004);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] o, d;
      logic [3:0]  s;
      o = offs[$urandom_range(0, NOFF - 1)] + 32'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 0);
      d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64));
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, BASE + o, d, s);
    end

    valid = 1'b1; instr = 1'b0; addr = BASE; wdata = 32'h1; wstrb = 4'hF;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    valid = 1'b0; wstrb = 4'h0;
    #1;
    chk("midrst_ready", ready, 1'b0);
    chk("midrst_msip", msip, 2'b00);
    chk("midrst_mtime", mtime, 64'h0);
    chk("midrst_mtip", mtip, 2'b00);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rd(32'h4000);
    chk("cmp_after_reset", rdata, 32'hFFFF_FFFF);
    rd(32'h400C);
    repeat (5) idle();
    chk("div1_count", mtime1, 40'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", neval, nfail);
    $finish;
  end

endmodule

// File: doc/clint_multi.md
Name: clint_multi

Overview:
- Multi-hart core-local interruptor that generates the machine timer and software interrupts.
- Sits on the peripheral memory bus at clint_base_addr.
- Generalises the fixed single-hart clint_divider_rtc timebase: tick ratio, hart count and mtime width are all parametrised.
- Supplies mtip/msip per hart and the shared mtime value used by the time CSR.

Parameters:
- harts, 1, number of harts served (1..16).
- clk_freq, 1000000000, core clock frequency in Hz.
- rtc_freq, 100000000, mtime tick frequency in Hz; clk_freq/rtc_freq must be an integer >= 1.
- base_addr, 32'h2000000, CLINT base address; address decode uses offset = mem_addr - base_addr, 16-bit window.
- time_width, 64, mtime/mtimecmp width (33..64).

Ports:
- reset  input  1  asynchronous active-low reset.
- clock  input  1  single system clock.
- mem_valid  input  1  request strobe.
- mem_instr  input  1  instruction-fetch flag; fetches read 0.
- mem_addr  input  32  byte address.
- mem_wdata  input  32  write data.
- mem_wstrb  input  4  byte write enables; 0 means read.
- mem_rdata  output  32  read data.
- mem_ready  output  1  one-cycle completion pulse.
- mtime_out  output  time_width  current mtime.
- mtip  output  harts  timer interrupt pending per hart.
- msip  output  harts  software interrupt pending per hart.

Behaviour:
- Reset (reset=0, async): all outputs are 0, except mtimecmp[*] = all ones; tick counter = 0.
- Tick generator:
  - div = clk_freq/rtc_freq; counter runs 0..div-1, tick pulses when counter = div-1, then the counter wraps to 0.
  - If div = 1, tick is asserted every cycle.
  - On tick, mtime += 1, wrapping modulo 2^time_width.
- Register map (offsets from base_addr, little-endian 32-bit words):
  - 0x0000+4*h: msip[h], bit 0 only; other bits read 0 and are ignored on write.
  - 0x4000+8*h: mtimecmp[h] low word.
  - 0x4004+8*h: mtimecmp[h] high word; bits above time_width read 0.
  - 0xBFF8: mtime low word.
  - 0xBFFC: mtime high word.
  - h >= harts, or any other offset: reads 0, writes ignored, still acknowledged.
- Handshake:
  - A request sampled with mem_valid=1 produces mem_ready=1 exactly one cycle later, for one cycle, with mem_rdata valid in that same cycle.
  - mem_rdata = 0 whenever mem_ready = 0.
  - Back-to-back requests are accepted every cycle; no stall.
- Writes: each byte lane is updated only when its wstrb bit is set, and the update takes effect at the clock edge that samples the request.
- Simultaneous mtime write and tick: the write wins for the written word; unwritten bytes take the incremented value.
- Reads return the register value before any write in the same cycle.
- mtip[h] is registered: set to (mtime >= mtimecmp[h]) using the mtime value after the current update. This gives one cycle of latency from an mtime or mtimecmp change, and the comparison is unsigned, full time_width.
- msip[h] is driven directly from its register bit.
- Misaligned addresses (mem_addr[1:0] != 0) are treated as the aligned word.
- Reset asserted mid-transaction: the pending mem_ready is dropped, no write commits, and all state returns to its reset values.

Test Plan:
- Reset, default params (div = 10): after 100 cycles, mtime_out = 10; mtip = 0; a read of 0xBFF8 returns 10 or 11 with mem_ready exactly one cycle after mem_valid.
- harts=2: write mtimecmp[1] = 0x0000_0000_0000_0020, with high word written before low word; at mtime = 0x20, mtip = 2'b10 one cycle later. Then write mtimecmp[1] high = 0xFFFFFFFF → mtip[1] = 0 one cycle later.
- Write 0x1 to 0x0004 → msip = 2'b10; write 0xFFFFFFFE to 0x0004 → msip = 0; read 0x0004 → 0.
- Write mtime low = 0xFFFFFFFF with wstrb 4'b1111 coincident with a tick → low = 0xFFFFFFFF, high unchanged; after the next tick, mtime = 0x1_0000_0000.
- Read 0x8000 and 0x4010 with harts = 2 → rdata = 0, mem_ready asserted; a write there changes no state. Byte write wstrb = 4'b0010, wdata = 0x0000AB00 to mtimecmp[0] low → only bits 15:8 become 0xAB.
- Assert reset mid-request after a write to msip is sampled → no mem_ready, msip = 0, mtimecmp = all ones; with div = 1, mtime increments every cycle after reset release.
